sdes_ctrl: RTL and testbench
============================

SDES_CTRL -- requirements
Module: sdes_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, number of RUN cycles the crypt operands are held before cipher is sampled (legal 1..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  request present; in_ready  output  1  controller can accept.
REQ-005 SHALL have port in_mode  input  1  0 = encrypt, 1 = decrypt.
REQ-006 SHALL have ports in_key  input  10  SDES key; in_data  input  8  plaintext or ciphertext.
REQ-007 SHALL have ports out_valid  output  1  result present; out_ready  input  1  consumer accepts; out_data  output  8  result.
REQ-008 SHALL have ports crypt_enable  output  1  crypt core clear (1 = clear, 0 = compute); crypt_q_in, crypt_key_1, crypt_key_2  output  8 each; crypt_cipher  input  8.
REQ-009 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, KEYGEN, RUN, DONE, one-hot or binary at implementer's choice.
REQ-011 IDLE: in_ready = 1; in_valid && in_ready at an edge captures in_key, in_data, in_mode and moves to KEYGEN.
REQ-012 KEYGEN (1 cycle): registers subkeys K1, K2 from the key schedule (P10, LS-1, P8 -> K1; LS-2, P8 -> K2); moves to RUN.
REQ-013 RUN: crypt_enable = 0, crypt_q_in = captured data; encrypt drives key_1 = K1, key_2 = K2; decrypt drives key_1 = K2, key_2 = K1.
REQ-014 RUN lasts exactly SETTLE_CYCLES cycles (4-bit down-counter); on the last RUN edge out_data <= crypt_cipher and the state moves to DONE.
REQ-015 Outside RUN: crypt_enable = 1, crypt_q_in/key_1/key_2 = 0.
REQ-016 DONE: out_valid = 1, out_data stable; out_valid && out_ready at an edge -> IDLE; out_valid held indefinitely while out_ready = 0.
REQ-017 Latency: out_valid rises SETTLE_CYCLES+2 edges after the accepting edge (cache miss); in_ready = 0 from the accepting edge until return to IDLE.
REQ-018 in_valid while not IDLE SHALL be ignored (no queueing); in_key/in_data changes after acceptance SHALL not affect the result.
REQ-019 out_ready while not DONE SHALL be ignored.
REQ-020 Throughput: back-to-back request accepted in the cycle after DONE handshake (IDLE one cycle minimum).

Reset
REQ-021 reset high at an edge SHALL force IDLE regardless of state, including mid-RUN or DONE with pending out_valid (result discarded).
REQ-022 Reset values: out_valid 0, out_data 0, crypt_enable 1, crypt operands 0, busy 0, K1/K2 0, settle counter 0, cache valid 0.
REQ-023 in_ready SHALL be 0 while reset is high, 1 in first cycle after reset deasserts.

Configuration
REQ-024 Macro SDES_KEY_CACHE_EN: when defined, the controller keeps the last expanded 10-bit key plus a valid flag; an accepted request whose in_key equals the cached key with valid = 1 skips KEYGEN (IDLE -> RUN), latency SETTLE_CYCLES+1.
REQ-025 Cache valid set on every KEYGEN completion, cleared by reset only.
REQ-026 When SDES_KEY_CACHE_EN is undefined every request passes through KEYGEN; no cache registers are synthesized.

Structure
REQ-027 Shared package sdes_pkg SHALL hold the state enumeration, P10/P8 index tables, MODE_ENC/MODE_DEC constants and key/block width constants.
REQ-028 Key schedule SHALL be sub-module sdes_key_sched (combinational, 10-bit key in, K1/K2 out), instantiated once; crypt core is external and connected through the crypt_* ports.

Verification
REQ-029 Key 1010101010, encrypt 11110000 -> crypt_key_1 11100100, crypt_key_2 01010011 during RUN; out_data 01011001 after SETTLE_CYCLES+2 edges.
REQ-030 Same key, encrypt 10101010 back-to-back -> out_data 01101011; with SDES_KEY_CACHE_EN, no KEYGEN cycle, latency SETTLE_CYCLES+1.
REQ-031 Key 1011111101, encrypt 11111110 -> out_data 11100110; decrypt 11100110 -> key_1 11111001, key_2 11011111, out_data 11111110.
REQ-032 Hold out_ready = 0 for 10 cycles in DONE -> out_valid and out_data stable; new in_valid ignored, in_ready 0.
REQ-033 Assert reset during RUN -> next cycle IDLE, crypt_enable 1, out_valid 0, cache invalid (next same-key request takes KEYGEN).
REQ-034 SETTLE_CYCLES = 4, key 1111100000, encrypt 10011001 -> crypt_enable low exactly 4 cycles, out_data 00111100.

Source files
------------

// File: rtl/sdes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdes_pkg
//  Description : Shared types and constants for the S-DES controller:
//                FSM state enumeration, key-schedule permutation tables,
//                mode encodings and key/block widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package sdes_pkg;

    localparam int c_KEY_W    = 10;
    localparam int c_BLK_W    = 8;
    localparam int c_SUBKEY_W = 8;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // Permutation tables use 1-based source positions, position 1 = MSB.
    localparam int c_P10 [c_KEY_W]    = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    localparam int c_P8  [c_SUBKEY_W] = '{6, 3, 7, 4, 8, 5, 10, 9};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_KEYGEN = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } sdes_state_t;

endpackage
`default_nettype wire

// File: rtl/sdes_key_sched.sv
`default_nettype none
// ============================================================================
//  Module      : sdes_key_sched
//  Description : Combinational S-DES key schedule.
//                K1 = P8(LS-1(P10(key))), K2 = P8(LS-2(LS-1(P10(key)))).
//  Revision    : 1.0 - initial release
// ============================================================================
module sdes_key_sched
    import sdes_pkg::*;
(
    input  logic [c_KEY_W-1:0]    i_key,
    output logic [c_SUBKEY_W-1:0] o_k1,
    output logic [c_SUBKEY_W-1:0] o_k2
);

    logic [c_KEY_W-1:0] w_p10;
    logic [c_KEY_W-1:0] w_ls1;
    logic [c_KEY_W-1:0] w_ls2;

    // Table position p (1 = MSB) lives at bit index WIDTH-p.
    for (genvar gi = 0; gi < c_KEY_W; gi++) begin : g_p10
        assign w_p10[c_KEY_W-1-gi] = i_key[c_KEY_W - c_P10[gi]];
    end

    // Each 5-bit half rotates independently.
    assign w_ls1 = {w_p10[8:5], w_p10[9], w_p10[3:0], w_p10[4]};
    assign w_ls2 = {w_ls1[7:5], w_ls1[9:8], w_ls1[2:0], w_ls1[4:3]};

    for (genvar gi = 0; gi < c_SUBKEY_W; gi++) begin : g_p8
        assign o_k1[c_SUBKEY_W-1-gi] = w_ls1[c_KEY_W - c_P8[gi]];
        assign o_k2[c_SUBKEY_W-1-gi] = w_ls2[c_KEY_W - c_P8[gi]];
    end

endmodule
`default_nettype wire

// File: rtl/sdes_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sdes_ctrl
//  Description : Request/response controller around an external S-DES crypt
//                core. Captures a request, expands the key, holds the crypt
//                operands for SETTLE_CYCLES cycles, then presents the result
//                until the consumer accepts it.
//                Optional feature macro: SDES_KEY_CACHE_EN (reuse the subkeys
//                of the last expanded key and skip the key schedule cycle).
//  Revision    : 1.0 - initial release
// ============================================================================
module sdes_ctrl
    import sdes_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [c_KEY_W-1:0]    in_key,
    input  logic [c_BLK_W-1:0]    in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [c_BLK_W-1:0]    out_data,
    output logic                  crypt_enable,
    output logic [c_BLK_W-1:0]    crypt_q_in,
    output logic [c_SUBKEY_W-1:0] crypt_key_1,
    output logic [c_SUBKEY_W-1:0] crypt_key_2,
    input  logic [c_BLK_W-1:0]    crypt_cipher,
    output logic                  busy
);

    localparam logic [3:0] c_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    sdes_state_t             r_state;
    sdes_state_t             w_state_nxt;
    logic [c_KEY_W-1:0]      r_key;
    logic [c_BLK_W-1:0]      r_data;
    logic                    r_mode;
    logic [c_SUBKEY_W-1:0]   r_k1;
    logic [c_SUBKEY_W-1:0]   r_k2;
    logic [3:0]              r_settle_cnt;
    logic [c_BLK_W-1:0]      r_out_data;
    logic [c_SUBKEY_W-1:0]   w_k1;
    logic [c_SUBKEY_W-1:0]   w_k2;
    logic                    w_accept;
    logic                    w_cache_hit;
    logic                    w_enter_run;
    logic                    w_run_last;

    assign w_accept    = in_valid && in_ready;
    assign w_enter_run = (w_accept && w_cache_hit) || (r_state == ST_KEYGEN);
    assign w_run_last  = (r_state == ST_RUN) && (r_settle_cnt == 4'd0);
    assign out_data    = r_out_data;

    sdes_key_sched u_key_sched (
        .i_key (r_key),
        .o_k1  (w_k1),
        .o_k2  (w_k2)
    );

`ifdef SDES_KEY_CACHE_EN
    logic [c_KEY_W-1:0] r_cache_key;
    logic               r_cache_valid;

    // Remember the last expanded key; its subkeys stay in r_k1/r_k2.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cache_valid <= 1'b0;
            r_cache_key   <= '0;
        end else if (r_state == ST_KEYGEN) begin
            r_cache_valid <= 1'b1;
            r_cache_key   <= r_key;
        end
    end

    assign w_cache_hit = r_cache_valid && (in_key == r_cache_key);
`else
    assign w_cache_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-state outputs; crypt operands are only live in RUN.
    always_comb begin
        w_state_nxt  = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        crypt_enable = 1'b1;
        crypt_q_in   = '0;
        crypt_key_1  = '0;
        crypt_key_2  = '0;
        case (r_state)
            ST_IDLE: begin
                busy     = 1'b0;
                in_ready = !reset;
                if (w_accept) begin
                    w_state_nxt = w_cache_hit ? ST_RUN : ST_KEYGEN;
                end
            end
            ST_KEYGEN: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                crypt_enable = 1'b0;
                crypt_q_in   = r_data;
                crypt_key_1  = (r_mode == MODE_DEC) ? r_k2 : r_k1;
                crypt_key_2  = (r_mode == MODE_DEC) ? r_k1 : r_k2;
                if (r_settle_cnt == 4'd0) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Capture the request so later input changes cannot disturb it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_key  <= '0;
            r_data <= '0;
            r_mode <= MODE_ENC;
        end else if (w_accept) begin
            r_key  <= in_key;
            r_data <= in_data;
            r_mode <= in_mode;
        end
    end

    // Subkeys are registered during the single key schedule cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_k1 <= '0;
            r_k2 <= '0;
        end else if (r_state == ST_KEYGEN) begin
            r_k1 <= w_k1;
            r_k2 <= w_k2;
        end
    end

    // Settle counter: loaded on RUN entry, counts down to the sampling cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_settle_cnt <= 4'd0;
        end else if (w_enter_run) begin
            r_settle_cnt <= c_SETTLE_LOAD;
        end else if ((r_state == ST_RUN) && (r_settle_cnt != 4'd0)) begin
            r_settle_cnt <= r_settle_cnt - 4'd1;
        end
    end

    // Sample the core result on the last RUN edge; held through DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data <= '0;
        end else if (w_run_last) begin
            r_out_data <= crypt_cipher;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdes_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdes_ctrl
//  Description : Self-checking bench for sdes_ctrl. Acts as the external
//                S-DES crypt core and keeps a transaction-level timing model
//                of the controller. Honours SDES_KEY_CACHE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdes_ctrl;

    localparam int SETTLE = 4;
`ifdef SDES_KEY_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic       in_mode;
    logic [9:0] in_key;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       crypt_enable;
    logic [7:0] crypt_q_in;
    logic [7:0] crypt_key_1;
    logic [7:0] crypt_key_2;
    logic [7:0] crypt_cipher;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    sdes_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mode      (in_mode),
        .in_key       (in_key),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .crypt_enable (crypt_enable),
        .crypt_q_in   (crypt_q_in),
        .crypt_key_1  (crypt_key_1),
        .crypt_key_2  (crypt_key_2),
        .crypt_cipher (crypt_cipher),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- S-DES reference functions ----------------
    function automatic logic [7:0] perm8(input logic [7:0] x, input logic [31:0] tbl);
        logic [7:0] y;
        int pos;
        y = '0;
        for (int i = 0; i < 8; i++) begin
            pos = int'(tbl[31-4*i -: 4]);
            y[7-i] = x[8-pos];
        end
        return y;
    endfunction

    function automatic logic [4:0] rotl5(input logic [4:0] x, input int n);
        logic [9:0] d;
        d = {x, x} << n;
        return d[9:5];
    endfunction

    // Returns {K1, K2}.
    function automatic logic [15:0] key_sched(input logic [9:0] k);
        logic [39:0] p10t;
        logic [31:0] p8t;
        logic [9:0]  t, s1, s2;
        logic [7:0]  k1, k2;
        int pos;
        p10t = 40'h35274A1986;
        p8t  = 32'h637485A9;
        t = '0; k1 = '0; k2 = '0;
        for (int i = 0; i < 10; i++) begin
            pos = int'(p10t[39-4*i -: 4]);
            t[9-i] = k[10-pos];
        end
        s1 = {rotl5(t[9:5], 1), rotl5(t[4:0], 1)};
        s2 = {rotl5(t[9:5], 3), rotl5(t[4:0], 3)};
        for (int i = 0; i < 8; i++) begin
            pos = int'(p8t[31-4*i -: 4]);
            k1[7-i] = s1[10-pos];
            k2[7-i] = s2[10-pos];
        end
        return {k1, k2};
    endfunction

    function automatic logic [3:0] fk(input logic [3:0] l, input logic [3:0] r, input logic [7:0] sk);
        logic [7:0]  t;
        logic [31:0] s0t, s1t;
        logic [1:0]  a, b;
        logic [3:0]  s;
        int i0, i1;
        s0t = 32'h4EE427DE;
        s1t = 32'h1B87C493;
        t  = perm8({r, 4'b0000}, 32'h41232341) ^ sk;
        i0 = 4 * int'({t[7], t[4]}) + int'({t[6], t[5]});
        i1 = 4 * int'({t[3], t[0]}) + int'({t[2], t[1]});
        a  = s0t[31-2*i0 -: 2];
        b  = s1t[31-2*i1 -: 2];
        s  = {a, b};
        return l ^ {s[2], s[0], s[1], s[3]};
    endfunction

    function automatic logic [7:0] sdes_core(input logic [7:0] d, input logic [7:0] ka, input logic [7:0] kb);
        logic [7:0] x;
        logic [3:0] l, r, nl;
        x  = perm8(d, 32'h26314857);
        l  = fk(x[7:4], x[3:0], ka);
        r  = x[3:0];
        nl = fk(r, l, kb);
        return perm8({nl, l}, 32'h41357286);
    endfunction

    // External crypt core stand-in.
    always_comb begin
        crypt_cipher = crypt_enable ? 8'h00 : sdes_core(crypt_q_in, crypt_key_1, crypt_key_2);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level timing model ----------------
    int         m       = 0;
    bit         started = 1'b0;
    bit         pending = 1'b0;
    bit         cache_v = 1'b0;
    int         kg      = 0;
    int         acc_e   = 0;
    int         done_e  = 0;
    logic [9:0] cache_k = '0;
    logic [9:0] m_key   = '0;
    logic [7:0] m_data  = '0;
    logic [7:0] m_k1    = '0;
    logic [7:0] m_k2    = '0;
    logic [7:0] m_ciph  = '0;
    logic [7:0] exp_out = '0;

    initial begin
        logic [15:0] sk;
        bit hit;
        forever begin
            @(posedge clk);
            m++;
            if (reset) begin
                pending = 1'b0;
                cache_v = 1'b0;
                exp_out = '0;
                started = 1'b1;
            end else if (pending) begin
                if (kg == 1 && m == acc_e + 1) begin
                    cache_k = m_key;
                    cache_v = 1'b1;
                end
                if (m == done_e) exp_out = m_ciph;
                else if (m > done_e && out_ready) pending = 1'b0;
            end else if (in_valid && started) begin
                hit     = CACHE && cache_v && (in_key == cache_k);
                kg      = hit ? 0 : 1;
                acc_e   = m;
                done_e  = m + kg + SETTLE;
                m_key   = in_key;
                m_data  = in_data;
                sk      = key_sched(in_key);
                m_k1    = in_mode ? sk[7:0]  : sk[15:8];
                m_k2    = in_mode ? sk[15:8] : sk[7:0];
                m_ciph  = sdes_core(in_data, m_k1, m_k2);
                pending = 1'b1;
            end
        end
    end

    // Compare the DUT against the model every cycle.
    initial begin
        bit run, dn;
        forever begin
            @(negedge clk);
            if (started) begin
                run = pending && (m >= acc_e + kg) && (m < done_e);
                dn  = pending && (m >= done_e);
                chk("in_ready",     32'(in_ready),     32'(!pending && !reset));
                chk("busy",         32'(busy),         32'(pending));
                chk("out_valid",    32'(out_valid),    32'(dn));
                chk("crypt_enable", 32'(crypt_enable), 32'(!run));
                chk("crypt_q_in",   32'(crypt_q_in),   32'(run ? m_data : 8'h00));
                chk("crypt_key_1",  32'(crypt_key_1),  32'(run ? m_k1 : 8'h00));
                chk("crypt_key_2",  32'(crypt_key_2),  32'(run ? m_k2 : 8'h00));
                chk("out_data",     32'(out_data),     32'(exp_out));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [9:0] k, input logic [7:0] d, input logic md, input int hold,
                        output logic [7:0] res, output int lat, output logic [7:0] k1s,
                        output logic [7:0] k2s, output int run_cnt);
        bit acc;
        int guard;
        in_valid = 1'b1; in_key = k; in_data = d; in_mode = md;
        acc = 1'b0; guard = 0;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #2;
            guard++;
        end
        chk("accept_timeout", 32'(acc), 32'd1);
        in_valid = 1'b0;
        in_key   = 10'($urandom);
        in_data  = 8'($urandom);
        in_mode  = 1'($urandom);
        lat = 1; run_cnt = 0; k1s = '0; k2s = '0; guard = 0;
        while (guard < 100) begin
            @(negedge clk);
            if (!crypt_enable) begin
                run_cnt++;
                k1s = crypt_key_1;
                k2s = crypt_key_2;
            end
            if (out_valid) break;
            @(posedge clk);
            #2;
            lat++;
            guard++;
        end
        chk("result_timeout", 32'(out_valid), 32'd1);
        res = out_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #2;
            in_valid = 1'b1;
            in_key   = 10'($urandom);
            in_data  = 8'($urandom);
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data",  32'(out_data),  32'(res));
            chk("hold_ready", 32'(in_ready),  32'd0);
        end
        @(posedge clk);
        #2;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] res, k1s, k2s;
        logic [9:0] pool [3];
        int lat, rc;
        pool[0] = 10'b1010101010;
        pool[1] = 10'b1011111101;
        pool[2] = 10'b1111100000;

        reset = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_key = '0; in_data = '0; out_ready = 1'b0;

        // Hand-computed values pin the reference model.
        chk("model_ks",   32'(key_sched(10'b1010101010)), 32'h0000E453);
        chk("model_enc1", 32'(sdes_core(8'b11110000, 8'b11100100, 8'b01010011)), 32'h59);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),     32'd0);
        chk("rst_out_valid", 32'(out_valid),    32'd0);
        chk("rst_crypt_en",  32'(crypt_enable), 32'd1);
        chk("rst_busy",      32'(busy),         32'd0);
        chk("rst_out_data",  32'(out_data),     32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #2;

        send(10'b1010101010, 8'b11110000, 1'b0, 0, res, lat, k1s, k2s, rc);
        chk("v1_out",  32'(res), 32'h59);
        chk("v1_k1",   32'(k1s), 32'hE4);
        chk("v1_k2",   32'(k2s), 32'h53);
        chk("v1_lat",  32'(lat), 32'(SETTLE + 2));

        send(10'b1010101010, 8'b10101010, 1'b0, 0, res, lat, k1s, k2s, rc);
        chk("v2_out",  32'(res), 32'h6B);
        chk("v2_lat",  32'(lat), 32'(CACHE ? SETTLE + 1 : SETTLE + 2));

        send(10'b1011111101, 8'b11111110, 1'b0, 0, res, lat, k1s, k2s, rc);
        chk("v3_enc",  32'(res), 32'hE6);
        send(10'b1011111101, 8'b11100110, 1'b1, 0, res, lat, k1s, k2s, rc);
        chk("v3_dec",  32'(res), 32'hFE);
        chk("v3_k1",   32'(k1s), 32'hF9);
        chk("v3_k2",   32'(k2s), 32'hDF);

        send(10'b1111100000, 8'b10011001, 1'b0, 10, res, lat, k1s, k2s, rc);
        chk("v4_out",  32'(res), 32'h3C);
        chk("v4_run",  32'(rc),  32'(SETTLE));

        // Reset in the middle of RUN discards the request and the cache.
        in_valid = 1'b1; in_key = 10'b1111100000; in_data = 8'h5A; in_mode = 1'b0;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_crypt_en", 32'(crypt_enable), 32'd1);
        chk("mid_rst_valid",    32'(out_valid),    32'd0);
        chk("mid_rst_busy",     32'(busy),         32'd0);
        @(posedge clk);
        #2;
        send(10'b1111100000, 8'b10011001, 1'b0, 0, res, lat, k1s, k2s, rc);
        chk("post_rst_out", 32'(res), 32'h3C);
        chk("post_rst_lat", 32'(lat), 32'(SETTLE + 2));

        // Randomised traffic, fully checked by the model.
        for (int c = 0; c < 500; c++) begin
            @(posedge clk);
            #2;
            reset     = ($urandom % 60) == 0;
            in_valid  = ($urandom % 3) == 0;
            in_key    = pool[$urandom % 3];
            in_data   = 8'($urandom);
            in_mode   = 1'($urandom);
            out_ready = ($urandom % 3) == 0;
        end

        @(posedge clk);
        #2;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
